// File: rtl/pixel_plot_arbiter.sv
// Pixel-write arbiter in front of vga_adapter: food/snake request FIFO, one registered plot per clock, full-screen clear sweep.
// Optional range clipping with a saturating drop counter is enabled by defining PLOT_ARB_CLIP_EN.
module pixel_plot_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned X_MAX        = 160,
  parameter int unsigned Y_MAX        = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       food_req,
  input  logic [7:0] food_x,
  input  logic [6:0] food_y,
  input  logic [2:0] food_colour,
  output logic       food_ready,
  input  logic       snake_req,
  input  logic [7:0] snake_x,
  input  logic [6:0] snake_y,
  input  logic [2:0] snake_colour,
  output logic       snake_ready,
  input  logic       clear_start,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       clear_done,
  output logic [7:0] drop_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned C_W   = 3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } pixel_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [X_W-1:0]   cx_q, cx_d;
  logic [Y_W-1:0]   cy_q, cy_d;
  pixel_t           vga_q, vga_d;
  logic             plot_q, plot_d;
  logic             done_q, done_d;
  pixel_t           mem_q [FIFO_DEPTH];

  logic   idle, full, accept, push, pop;
  pixel_t req_pix;

  assign idle        = (state_q == IDLE);
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign food_ready  = !full && idle;
  assign snake_ready = !full && idle && !food_req;
  assign accept      = (food_req && food_ready) || (snake_req && snake_ready);
  assign req_pix     = food_req ? pixel_t'{food_x, food_y, food_colour}
                                : pixel_t'{snake_x, snake_y, snake_colour};
  // A starting clear owns this edge, so the head entry waits for the sweep to end.
  assign pop         = idle && !clear_start && (count_q != '0);

`ifdef PLOT_ARB_CLIP_EN
  logic       in_range;
  logic [7:0] drop_q, drop_d;

  assign in_range = (32'(req_pix.x) < X_MAX) && (32'(req_pix.y) < Y_MAX);
  assign push     = accept && in_range;

  always_comb begin
    drop_d = drop_q;
    if (accept && !in_range && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign push       = accept;
  assign drop_count = '0;
`endif

  // Storage only; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_pix;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    vga_d    = vga_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end else if (pop) begin
          vga_d    = mem_q[rd_ptr_q];
          plot_d   = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
      CLEAR: begin
        vga_d  = pixel_t'{cx_q, cy_q, CLEAR_COLOUR};
        plot_d = 1'b1;
        if (cx_q == X_W'(X_MAX - 1)) begin
          cx_d = '0;
          if (cy_q == Y_W'(Y_MAX - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cy_d = cy_q + Y_W'(1);
          end
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      vga_q    <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      vga_q    <= vga_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign vga_x      = vga_q.x;
  assign vga_y      = vga_q.y;
  assign vga_colour = vga_q.colour;
  assign vga_plot   = plot_q;
  assign clear_done = done_q;
  assign busy       = !idle || (count_q != '0);

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// Directed bench for pixel_plot_arbiter; a small-screen second instance makes FIFO-full reachable in few cycles.
module tb_pixel_plot_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       food_req = 1'b0, snake_req = 1'b0, clear_start = 1'b0;
  logic [7:0] food_x = '0, snake_x = '0;
  logic [6:0] food_y = '0, snake_y = '0;
  logic [2:0] food_colour = '0, snake_colour = '0;

  logic       m_food_ready, m_snake_ready, m_plot, m_busy, m_done;
  logic [7:0] m_x, m_drop;
  logic [6:0] m_y;
  logic [2:0] m_c;

  logic       s_food_ready, s_snake_ready, s_plot, s_busy, s_done;
  logic [7:0] s_x, s_drop;
  logic [6:0] s_y;
  logic [2:0] s_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_plot_arbiter dut (
    .clk(clk), .reset(reset),
    .food_req(food_req), .food_x(food_x), .food_y(food_y), .food_colour(food_colour),
    .food_ready(m_food_ready),
    .snake_req(snake_req), .snake_x(snake_x), .snake_y(snake_y), .snake_colour(snake_colour),
    .snake_ready(m_snake_ready),
    .clear_start(clear_start),
    .vga_x(m_x), .vga_y(m_y), .vga_colour(m_c), .vga_plot(m_plot),
    .busy(m_busy), .clear_done(m_done), .drop_count(m_drop)
  );

  pixel_plot_arbiter #(.X_MAX(4), .Y_MAX(3)) dut_s (
    .clk(clk), .reset(reset),
    .food_req(food_req), .food_x(food_x), .food_y(food_y), .food_colour(food_colour),
    .food_ready(s_food_ready),
    .snake_req(snake_req), .snake_x(snake_x), .snake_y(snake_y), .snake_colour(snake_colour),
    .snake_ready(s_snake_ready),
    .clear_start(clear_start),
    .vga_x(s_x), .vga_y(s_y), .vga_colour(s_c), .vga_plot(s_plot),
    .busy(s_busy), .clear_done(s_done), .drop_count(s_drop)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    checks++;
    if ({m_plot, m_x, m_y, m_c, m_done, m_drop, m_busy} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", {m_plot, m_x, m_y, m_c, m_done, m_drop, m_busy}, 28'h0);
    end
    tick;
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if ({m_food_ready, m_snake_ready, m_busy} !== 3'b110) begin
      errors++;
      $display("FAIL reset_ready: got %b expected %b", {m_food_ready, m_snake_ready, m_busy}, 3'b110);
    end
  endtask

  task automatic test_single;
    food_req = 1'b1; food_x = 8'd10; food_y = 7'd20; food_colour = 3'b100;
    tick;
    food_req = 1'b0;
    checks++;
    if ({m_plot, m_busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_queued: got %b expected %b", {m_plot, m_busy}, 2'b01);
    end
    tick;
    checks++;
    if ({m_plot, m_x, m_y, m_c} !== {1'b1, 8'd10, 7'd20, 3'b100}) begin
      errors++;
      $display("FAIL single_plot: got %h expected %h", {m_plot, m_x, m_y, m_c}, {1'b1, 8'd10, 7'd20, 3'b100});
    end
    tick;
    checks++;
    if ({m_plot, m_x, m_y, m_c, m_busy} !== {1'b0, 8'd10, 7'd20, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL single_after: got %h expected %h", {m_plot, m_x, m_y, m_c, m_busy},
               {1'b0, 8'd10, 7'd20, 3'b100, 1'b0});
    end
  endtask

  task automatic test_priority;
    logic [17:0] exp_pix [4];
    exp_pix[0] = {8'd1, 7'd1, 3'd1};
    exp_pix[1] = {8'd2, 7'd2, 3'd2};
    exp_pix[2] = {8'd3, 7'd3, 3'd3};
    exp_pix[3] = {8'd50, 7'd50, 3'd5};
    snake_req = 1'b1; snake_x = 8'd50; snake_y = 7'd50; snake_colour = 3'd5;
    for (int k = 0; k < 3; k++) begin
      food_req = 1'b1; food_x = 8'(k + 1); food_y = 7'(k + 1); food_colour = 3'(k + 1);
      #1;
      checks++;
      if ({m_food_ready, m_snake_ready} !== 2'b10) begin
        errors++;
        $display("FAIL prio_ready_%0d: got %b expected %b", k, {m_food_ready, m_snake_ready}, 2'b10);
      end
      tick;
      if (k > 0) begin
        checks++;
        if ({m_plot, m_x, m_y, m_c} !== {1'b1, exp_pix[k-1]}) begin
          errors++;
          $display("FAIL prio_order_%0d: got %h expected %h", k, {m_plot, m_x, m_y, m_c}, {1'b1, exp_pix[k-1]});
        end
      end
    end
    food_req = 1'b0;
    #1;
    checks++;
    if (m_snake_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_snake_ready: got %b expected %b", m_snake_ready, 1'b1);
    end
    tick;
    snake_req = 1'b0;
    for (int k = 2; k < 4; k++) begin
      checks++;
      if ({m_plot, m_x, m_y, m_c} !== {1'b1, exp_pix[k]}) begin
        errors++;
        $display("FAIL prio_order_%0d: got %h expected %h", k + 1, {m_plot, m_x, m_y, m_c}, {1'b1, exp_pix[k]});
      end
      tick;
    end
    checks++;
    if ({m_plot, m_busy} !== 2'b00) begin
      errors++;
      $display("FAIL prio_drained: got %b expected %b", {m_plot, m_busy}, 2'b00);
    end
  endtask

  task automatic test_clip;
`ifdef PLOT_ARB_CLIP_EN
    food_req = 1'b1; food_x = 8'd160; food_y = 7'd5; food_colour = 3'd1;
    #1;
    checks++;
    if (m_food_ready !== 1'b1) begin
      errors++;
      $display("FAIL clip_ready: got %b expected %b", m_food_ready, 1'b1);
    end
    tick;
    food_req = 1'b0;
    tick;
    checks++;
    if ({m_plot, m_busy, m_drop} !== {1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL clip_drop_x: got %h expected %h", {m_plot, m_busy, m_drop}, {1'b0, 1'b0, 8'd1});
    end
    food_req = 1'b1; food_x = 8'd0; food_y = 7'd120;
    tick;
    food_req = 1'b0;
    tick;
    checks++;
    if ({m_plot, m_drop} !== {1'b0, 8'd2}) begin
      errors++;
      $display("FAIL clip_drop_y: got %h expected %h", {m_plot, m_drop}, {1'b0, 8'd2});
    end
    food_req = 1'b1; food_x = 8'd160; food_y = 7'd5;
    repeat (300) tick;
    food_req = 1'b0;
    tick;
    checks++;
    if ({m_plot, m_drop} !== {1'b0, 8'd255}) begin
      errors++;
      $display("FAIL clip_saturate: got %h expected %h", {m_plot, m_drop}, {1'b0, 8'd255});
    end
`else
    food_req = 1'b1; food_x = 8'd160; food_y = 7'd5; food_colour = 3'd1;
    tick;
    food_req = 1'b0;
    tick;
    checks++;
    if ({m_plot, m_x, m_y, m_c, m_drop} !== {1'b1, 8'd160, 7'd5, 3'd1, 8'd0}) begin
      errors++;
      $display("FAIL noclip_pass: got %h expected %h", {m_plot, m_x, m_y, m_c, m_drop},
               {1'b1, 8'd160, 7'd5, 3'd1, 8'd0});
    end
`endif
  endtask

  // Each clear_start edge in IDLE also accepts one entry while the pop is withheld, so eight sweeps fill the FIFO.
  task automatic test_fifo_full;
    logic seen;
    for (int i = 0; i < 8; i++) begin
      snake_req = 1'b1; snake_x = 8'(i % 4); snake_y = 7'(i % 3); snake_colour = 3'(i);
      clear_start = 1'b1;
      #1;
      checks++;
      if (s_snake_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_accept_%0d: got %b expected %b", i, s_snake_ready, 1'b1);
      end
      tick;
      clear_start = 1'b0;
      if (i == 0) begin
        checks++;
        if ({s_snake_ready, s_busy} !== 2'b01) begin
          errors++;
          $display("FAIL full_stall_ready: got %b expected %b", {s_snake_ready, s_busy}, 2'b01);
        end
      end
      snake_req = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 30 && !seen; t++) begin
        tick;
        if (s_done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b1) begin
        errors++;
        $display("FAIL full_sweep_done_%0d: got %b expected %b", i, seen, 1'b1);
      end
    end
    snake_req = 1'b1; snake_x = 8'd3; snake_y = 7'd2; snake_colour = 3'd7;
    #1;
    checks++;
    if ({s_snake_ready, s_busy} !== 2'b01) begin
      errors++;
      $display("FAIL full_ninth: got %b expected %b", {s_snake_ready, s_busy}, 2'b01);
    end
    snake_req = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick;
      checks++;
      if ({s_plot, s_x, s_y, s_c} !== {1'b1, 8'(j % 4), 7'(j % 3), 3'(j)}) begin
        errors++;
        $display("FAIL full_drain_%0d: got %h expected %h", j, {s_plot, s_x, s_y, s_c},
                 {1'b1, 8'(j % 4), 7'(j % 3), 3'(j)});
      end
    end
    tick;
    checks++;
    if ({s_plot, s_busy, s_snake_ready} !== 3'b001) begin
      errors++;
      $display("FAIL full_empty: got %b expected %b", {s_plot, s_busy, s_snake_ready}, 3'b001);
    end
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_clear;
    int bad = 0;
    int first_bad = -1;
    logic [19:0] got, exp;
    clear_start = 1'b1;
    tick;
    clear_start = 1'b0;
    checks++;
    if ({m_plot, m_busy} !== 2'b01) begin
      errors++;
      $display("FAIL clear_enter: got %b expected %b", {m_plot, m_busy}, 2'b01);
    end
    for (int i = 0; i < 19200; i++) begin
      clear_start = (i == 100);
      tick;
      got = {m_plot, m_x, m_y, m_c, m_done};
      exp = {1'b1, 8'(i % 160), 7'(i / 160), 3'b000, 1'(i == 19199)};
      if (got !== exp || m_busy !== (i != 19199)) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = i;
          $display("clear pixel %0d: got %h/busy %b expected %h", i, got, m_busy, exp);
        end
      end
    end
    clear_start = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clear_sweep: got %0d bad pixels (first %0d) expected 0", bad, first_bad);
    end
    tick;
    checks++;
    if ({m_plot, m_done, m_busy} !== 3'b000) begin
      errors++;
      $display("FAIL clear_end: got %b expected %b", {m_plot, m_done, m_busy}, 3'b000);
    end
  endtask

  task automatic test_reset_mid;
    logic seen_done = 1'b0;
    food_req = 1'b1; food_x = 8'd9; food_y = 7'd9; food_colour = 3'd6;
    clear_start = 1'b1;
    tick;
    food_req = 1'b0;
    clear_start = 1'b0;
    repeat (4851) tick;
    checks++;
    if ({m_plot, m_x, m_y, m_busy} !== {1'b1, 8'd50, 7'd30, 1'b1}) begin
      errors++;
      $display("FAIL midreset_pos: got %h expected %h", {m_plot, m_x, m_y, m_busy}, {1'b1, 8'd50, 7'd30, 1'b1});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({m_plot, m_x, m_y, m_c, m_done, m_busy} !== 21'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected %h", {m_plot, m_x, m_y, m_c, m_done, m_busy}, 21'h0);
    end
    tick;
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick;
      if (m_done || m_plot) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: got %b expected %b", seen_done, 1'b0);
    end
    food_req = 1'b1; food_x = 8'd7; food_y = 7'd8; food_colour = 3'd2;
    tick;
    food_req = 1'b0;
    tick;
    checks++;
    if ({m_plot, m_x, m_y, m_c} !== {1'b1, 8'd7, 7'd8, 3'd2}) begin
      errors++;
      $display("FAIL midreset_next: got %h expected %h", {m_plot, m_x, m_y, m_c}, {1'b1, 8'd7, 7'd8, 3'd2});
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_priority;
    test_clip;
    test_fifo_full;
    test_clear;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
